stopwatch_ctrl: RTL and testbench

Sequencing controller for a chain of N_DIG external mod-10 decade counters (each with enable, synchronous clear, and an overflow flag high while its count is 9). It divides clk into a count tick and runs a start/stop/lap/clear state machine. It builds the cascaded per-digit enables from the counters' overflow flags and provides a lap-freeze display path. It sits between the push-button pulse logic and the digit counters / display decoder.

---
 rtl/stopwatch_ctrl.sv | 158 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: run/pause/lap/clear state machine,
// count-tick prescaler, cascaded decade-counter enables and a lap-freeze
// display path.  The digit counters themselves live outside this block.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 1000,
    parameter int N_DIG    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start_stop,
    input  logic               i_lap,
    input  logic               i_clear,
    input  logic [N_DIG-1:0]   i_dig_ovf,
    input  logic [4*N_DIG-1:0] i_dig_count,
    output logic [N_DIG-1:0]   o_dig_enb,
    output logic               o_dig_clr,
    output logic [4*N_DIG-1:0] o_disp,
    output logic [1:0]         o_state,
    output logic               o_running,
    output logic               o_rollover
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [PRE_W-1:0]     pre_cnt_r;
    logic                 tick_r;
    logic [4*N_DIG-1:0]   lap_r;
    logic                 dig_clr_r;
    logic                 running_r;
    logic                 acc_clear_s;
    logic                 start_s;
    logic                 capture_s;
    logic                 running_s;
    logic                 chain_s;
    logic [N_DIG-1:0]     dig_enb_s;
    logic                 roll_s;

    // Decode which pulse (if any) is accepted this cycle, by priority and legality
    always_comb begin
        state_nxt_s = state_r;
        acc_clear_s = 1'b0;
        start_s     = 1'b0;
        capture_s   = 1'b0;
        running_s   = (state_r == ST_RUN) || (state_r == ST_LAP);
        case (state_r)
            ST_IDLE: begin
                if (i_clear) begin
                    acc_clear_s = 1'b1;
                end else if (i_start_stop) begin
                    state_nxt_s = ST_RUN;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_start_stop) begin
                    state_nxt_s = ST_PAUSE;
                end else if (i_lap) begin
                    state_nxt_s = ST_LAP;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LAP: begin
                if (i_start_stop) begin
                    state_nxt_s = ST_PAUSE;
                end else if (i_lap) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LAP;
                end
            end
            ST_PAUSE: begin
                if (i_clear) begin
                    state_nxt_s = ST_IDLE;
                    acc_clear_s = 1'b1;
                end else if (i_start_stop) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, prescaler, tick, lap capture and clear pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
            pre_cnt_r <= {PRE_W{1'b0}};
            tick_r    <= 1'b0;
            lap_r     <= {(4*N_DIG){1'b0}};
            dig_clr_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            running_r <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_LAP);
            dig_clr_r <= acc_clear_s;
            if (capture_s) begin
                lap_r <= i_dig_count;
            end else begin
                lap_r <= lap_r;
            end
            // A fresh start or a clear restarts the tick period from zero;
            // a pause simply holds the partial period.
            if (acc_clear_s || start_s) begin
                pre_cnt_r <= {PRE_W{1'b0}};
                tick_r    <= 1'b0;
            end else if (running_s) begin
                if (pre_cnt_r == PRE_MAX) begin
                    pre_cnt_r <= {PRE_W{1'b0}};
                    tick_r    <= 1'b1;
                end else begin
                    pre_cnt_r <= pre_cnt_r + PRE_ONE;
                    tick_r    <= 1'b0;
                end
            end else begin
                pre_cnt_r <= pre_cnt_r;
                tick_r    <= 1'b0;
            end
        end
    end

    // Ripple-style cascade: digit k counts when the tick is up and all lower digits sit at 9
    always_comb begin
        chain_s   = tick_r;
        dig_enb_s = {N_DIG{1'b0}};
        for (int k = 0; k < N_DIG; k++) begin
            dig_enb_s[k] = chain_s;
            chain_s      = chain_s & i_dig_ovf[k];
        end
        roll_s = chain_s;
    end

    assign o_dig_enb  = dig_enb_s;
    assign o_rollover = roll_s;
    assign o_dig_clr  = dig_clr_r;
    assign o_state    = state_r;
    assign o_running  = running_r;
    assign o_disp     = (state_r == ST_LAP) ? lap_r : i_dig_count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with two behavioural decade counters.
// The reference model tracks total running time and derives ticks, the
// displayed value and the mode from that.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int ND = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start_stop = 1'b0;
    logic          i_lap = 1'b0;
    logic          i_clear = 1'b0;
    logic [ND-1:0] i_dig_ovf;
    logic [4*ND-1:0] i_dig_count;
    logic [ND-1:0] o_dig_enb;
    logic          o_dig_clr;
    logic [4*ND-1:0] o_disp;
    logic [1:0]    o_state;
    logic          o_running;
    logic          o_rollover;

    logic [3:0] cnt0_r;
    logic [3:0] cnt1_r;

    int n_total = 0;
    int n_bad   = 0;
    int n_roll  = 0;

    // reference model
    int m_state;
    int m_elapsed;
    int m_count;
    int m_lap;
    bit m_tick;
    bit m_clr;

    stopwatch_ctrl #(.TICK_DIV(TD), .N_DIG(ND)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start_stop (i_start_stop),
        .i_lap        (i_lap),
        .i_clear      (i_clear),
        .i_dig_ovf    (i_dig_ovf),
        .i_dig_count  (i_dig_count),
        .o_dig_enb    (o_dig_enb),
        .o_dig_clr    (o_dig_clr),
        .o_disp       (o_disp),
        .o_state      (o_state),
        .o_running    (o_running),
        .o_rollover   (o_rollover)
    );

    always #5 clk = ~clk;

    // External mod-10 digit counters driven by the controller
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0_r <= 4'd0;
            cnt1_r <= 4'd0;
        end else begin
            if (o_dig_clr) cnt0_r <= 4'd0;
            else if (o_dig_enb[0]) cnt0_r <= (cnt0_r == 4'd9) ? 4'd0 : cnt0_r + 4'd1;
            if (o_dig_clr) cnt1_r <= 4'd0;
            else if (o_dig_enb[1]) cnt1_r <= (cnt1_r == 4'd9) ? 4'd0 : cnt1_r + 4'd1;
        end
    end

    assign i_dig_ovf   = {cnt1_r == 4'd9, cnt0_r == 4'd9};
    assign i_dig_count = {cnt1_r, cnt0_r};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_elapsed = 0; m_count = 0; m_lap = 0; m_tick = 1'b0; m_clr = 1'b0;
    endtask

    // Advance the model across one clock edge given the pulses sampled there
    task automatic model_step(input bit ss, input bit lp, input bit cl);
        bit old_run;
        int old_cnt;
        old_run = (m_state == 1) || (m_state == 3);
        old_cnt = m_count;
        if (m_clr) m_count = 0;
        else if (m_tick) m_count = (m_count + 1) % 100;
        m_clr  = 1'b0;
        m_tick = 1'b0;
        if (old_run) begin
            m_elapsed++;
            m_tick = (m_elapsed % TD) == 0;
        end
        if (cl && (m_state == 0 || m_state == 2)) begin
            m_state = 0; m_clr = 1'b1; m_elapsed = 0;
        end else if (ss) begin
            if (m_state == 0) begin m_state = 1; m_elapsed = 0; end
            else if (m_state == 2) m_state = 1;
            else m_state = 2;
        end else if (lp && old_run) begin
            if (m_state == 1) begin m_state = 3; m_lap = old_cnt; end
            else m_state = 1;
        end
    endtask

    task automatic check_all();
        logic [1:0] e_enb;
        e_enb = {m_tick && (m_count % 10 == 9), m_tick};
        chk("state", 32'(o_state), 32'(m_state));
        chk("running", 32'(o_running), 32'((m_state == 1) || (m_state == 3)));
        chk("enb", 32'(o_dig_enb), 32'(e_enb));
        chk("rollover", 32'(o_rollover), 32'(m_tick && m_count == 99));
        chk("dig_clr", 32'(o_dig_clr), 32'(m_clr));
        chk("disp", 32'(o_disp), 32'(bcd(m_state == 3 ? m_lap : m_count)));
        if (o_rollover) n_roll++;
    endtask

    task automatic cyc(input bit ss, input bit lp, input bit cl);
        @(negedge clk);
        i_start_stop = ss; i_lap = lp; i_clear = cl;
        @(posedge clk);
        model_step(ss, lp, cl);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        // reset held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_enb", 32'(o_dig_enb), 32'd0);
        chk("rst_clr", 32'(o_dig_clr), 32'd0);
        chk("rst_roll", 32'(o_rollover), 32'd0);
        chk("rst_disp", 32'(o_disp), 32'h00);
        @(negedge clk);
        rst = 1'b1;
        idle(20);

        // counting, cascade at 0x09, ten ticks give 0x10
        cyc(1'b1, 1'b0, 1'b0);
        idle(41);
        chk("ten_ticks", 32'(o_disp), 32'h10);

        // run well past 0x99 to see the wrap
        idle(400);
        chk("roll_seen", 32'(n_roll > 0), 32'd1);

        // lap freeze and release
        cyc(1'b0, 1'b1, 1'b0);
        chk("lap_state", 32'(o_state), 32'b11);
        idle(17);
        cyc(1'b0, 1'b1, 1'b0);
        idle(6);

        // clear ignored in RUN, pause, resume keeps partial period, pause+clear
        cyc(1'b0, 1'b0, 1'b1);
        idle(2);
        cyc(1'b1, 1'b0, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0, 1'b0);
        idle(9);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("clr_pulse", 32'(o_dig_clr), 32'd1);
        idle(3);
        chk("clr_disp", 32'(o_disp), 32'h00);

        // clear beats start_stop in PAUSE
        cyc(1'b1, 1'b0, 1'b0);
        idle(10);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("prio_state", 32'(o_state), 32'd0);
        chk("prio_clr", 32'(o_dig_clr), 32'd1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0);
        end

        // asynchronous reset mid-run
        if (m_state == 0 || m_state == 2) cyc(1'b1, 1'b0, 1'b0);
        idle(7);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_state", 32'(o_state), 32'd0);
        chk("arst_run", 32'(o_running), 32'd0);
        chk("arst_enb", 32'(o_dig_enb), 32'd0);
        chk("arst_roll", 32'(o_rollover), 32'd0);
        chk("arst_disp", 32'(o_disp), 32'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        idle(12);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
